gray_counter: RTL
=================

GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; legal range 2..32.
REQ-002 Parameter SATURATE, default 0: 0 = counter wraps at its limits; 1 = counter holds at its limits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  count enable; one step per cycle while high.
REQ-006 up_dn  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 load  input  1  synchronous load strobe.
REQ-008 load_bin  input  WIDTH  binary value loaded when load=1.
REQ-009 bin_out  output  WIDTH  registered binary count.
REQ-010 gray_out  output  WIDTH  registered Gray code of bin_out.
REQ-011 wrap  output  1  registered one-cycle pulse: the count rolled over on the last edge.
REQ-012 at_max  output  1  registered flag: bin_out equals all ones.
REQ-013 at_min  output  1  registered flag: bin_out equals zero.

Function
REQ-014 The block SHALL hold one binary state register; every output SHALL be a register, with no combinational input-to-output path.
REQ-015 gray_out SHALL always equal bin_out XOR (bin_out >> 1): MSB copied, bit i = bin[i+1] XOR bin[i]. Both outputs SHALL update on the same edge.
REQ-016 Priority per edge SHALL be rst > load > en; up_dn SHALL be ignored unless en=1 and load=0.
REQ-017 Load: bin_out <= load_bin; gray_out <= gray(load_bin); wrap <= 0. The same edge SHALL NOT also apply a count step.
REQ-018 en=1, up_dn=1, bin_out < max: bin_out <= bin_out+1; wrap <= 0.
REQ-019 en=1, up_dn=1, bin_out = max, SATURATE=0: bin_out <= 0; wrap <= 1.
REQ-020 en=1, up_dn=0, bin_out > 0: bin_out <= bin_out-1; wrap <= 0.
REQ-021 en=1, up_dn=0, bin_out = 0, SATURATE=0: bin_out <= max; wrap <= 1.
REQ-022 SATURATE=1 at a limit (up at max, or down at 0): bin_out SHALL hold; wrap <= 0.
REQ-023 en=0 with load=0: all state SHALL hold; wrap <= 0.
REQ-024 Latency: a control input sampled on edge N SHALL be visible on the outputs after edge N; throughput is one step per cycle.
REQ-025 Arithmetic SHALL be unsigned modulo 2^WIDTH; max = 2^WIDTH-1.
REQ-026 at_max and at_min SHALL be computed from the next-state value and registered, so they stay consistent with bin_out in every cycle.
REQ-027 Across any single count step, including a wrap, gray_out SHALL change in exactly one bit. Load, hold and saturate edges are exempt.
REQ-028 The block has no FSM beyond the counter register. wrap is the only pulse output and SHALL never be high for two consecutive cycles unless consecutive wraps occur.

Reset
REQ-029 On an rst=1 edge: bin_out=0, gray_out=0, wrap=0, at_max=0, at_min=1. rst SHALL override load and en on the same edge.
REQ-030 Reset asserted mid-count SHALL abandon the count with no residual wrap pulse. Counting resumes from 0 on the first en edge after rst deasserts.

Verification (WIDTH=4)
REQ-031 Reset: rst=1 for 2 cycles with en=1 and load=1 -> bin_out=0000, gray_out=0000, wrap=0, at_min=1.
REQ-032 Up count: en=1, up_dn=1 from 0 for 16 edges.
- gray_out sequence: 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000.
- wrap=1 only on the 1111->0000 edge.
- Every step has Hamming distance 1.
REQ-033 Down wrap: from 0, en=1, up_dn=0 -> bin_out=1111, gray_out=1000, wrap=1, at_max=1; next edge -> bin_out=1110, gray_out=1001, wrap=0.
REQ-034 Load priority: load=1, load_bin=1010, en=1, up_dn=1 -> bin_out=1010, gray_out=1111, wrap=0; next edge (load=0) -> bin_out=1011, gray_out=1110.
REQ-035 Saturate (SATURATE=1):
- up at 1111 for 3 edges -> bin_out stays 1111, gray_out=1000, wrap=0.
- down at 0000 -> stays 0000.
REQ-036 Random: 10k cycles of random en, up_dn, load, rst, WIDTH in {2, 4, 8}, against a scoreboard model. Checks:
- gray_out == bin ^ (bin >> 1) every cycle.
- flags match the model.
- single-bit Gray change on every count step.

Source files
------------

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code mirror, rollover pulse
// and limit flags. Optional saturation at the limits instead of wrapping.
module gray_counter #(
    parameter int WIDTH    = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;
    logic             r_at_max;
    logic             r_at_min;

    logic [WIDTH-1:0] w_bin_next;
    logic [WIDTH-1:0] w_gray_next;
    logic             w_wrap_next;

    // Next-state selection; rst is applied in the register stage so it
    // overrides everything decided here.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal (no latches).
        w_bin_next  = r_bin;
        w_wrap_next = 1'b0;
        if (load) begin
            w_bin_next = load_bin;
        end else if (en) begin
            if (up_dn) begin
                if (r_bin == MAX_VAL) begin
                    if (!SATURATE) begin
                        w_bin_next  = '0;
                        w_wrap_next = 1'b1;
                    end
                end else begin
                    w_bin_next = r_bin + WIDTH'(1);
                end
            end else begin
                if (r_bin == '0) begin
                    if (!SATURATE) begin
                        w_bin_next  = MAX_VAL;
                        w_wrap_next = 1'b1;
                    end
                end else begin
                    w_bin_next = r_bin - WIDTH'(1);
                end
            end
        end
        w_gray_next = w_bin_next ^ (w_bin_next >> 1);
    end

    // Flags and Gray code derive from the next state so they share an edge
    // with bin_out and can never disagree with it.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all sequential state.
        if (rst) begin
            r_bin    <= '0;
            r_gray   <= '0;
            r_wrap   <= 1'b0;
            r_at_max <= 1'b0;
            r_at_min <= 1'b1;
        end else begin
            r_bin    <= w_bin_next;
            r_gray   <= w_gray_next;
            r_wrap   <= w_wrap_next;
            r_at_max <= (w_bin_next == MAX_VAL);
            r_at_min <= (w_bin_next == '0);
        end
    end

    assign bin_out  = r_bin;
    assign gray_out = r_gray;
    assign wrap     = r_wrap;
    assign at_max   = r_at_max;
    assign at_min   = r_at_min;

endmodule
